// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing controller: state encoding
// and default widths/timeouts.
package mul_share_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_CLR   = 3'd1;
  localparam logic [ST_W-1:0] S_START = 3'd2;
  localparam logic [ST_W-1:0] S_WAIT  = 3'd3;
  localparam logic [ST_W-1:0] S_RESP  = 3'd4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_CLR   = S_CLR,
    ST_START = S_START,
    ST_WAIT  = S_WAIT,
    ST_RESP  = S_RESP
  } state_e;

  localparam int DEF_OP_W    = 8;
  localparam int DEF_RES_W   = 2 * DEF_OP_W;
  localparam int DEF_TMO_CYC = 64;

endpackage

// File: rtl/mul_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping around; returns one-hot grant plus its index.
module mul_share_ctrl_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    // First pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    for (int j = 0; j < N_REQ; j++) begin
      if (!vld && req[j] && (IDX_W'(j) >= ptr)) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!vld && req[j]) begin
        vld    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Time-shares one iterative multiplier between N_REQ requesters: round-robin
// grant, operand capture, clear/start sequencing and product return.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int OP_W    = DEF_OP_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*OP_W-1:0] a_flat,
  input  logic [N_REQ*OP_W-1:0] b_flat,
  output logic [N_REQ-1:0]      ack,
  output logic [N_REQ-1:0]      done,
  output logic                  err,
  output logic [RES_W-1:0]      result_o,
  output logic                  busy,
  output logic [OP_W-1:0]       mul_a,
  output logic [OP_W-1:0]       mul_b,
  output logic                  mul_start,
  output logic                  mul_rst,
  input  logic                  mul_busy,
  input  logic [RES_W-1:0]      mul_result
);

  localparam int IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TMO_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  g_q, g_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              err_q, err_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic [OP_W-1:0]   mul_a_q, mul_a_d;
  logic [OP_W-1:0]   mul_b_q, mul_b_d;
  logic              mul_start_q, mul_start_d;
  logic              mul_rst_q, mul_rst_d;

  logic [N_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [OP_W-1:0]   a_sel, b_sel;

  mul_share_ctrl_rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_rr_pick (
    .req(req),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .vld(pick_vld)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (pick_gnt[j]) begin
        a_sel = a_flat[j*OP_W +: OP_W];
        b_sel = b_flat[j*OP_W +: OP_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    ack_d       = '0;
    done_d      = '0;
    err_d       = 1'b0;
    mul_start_d = 1'b0;
    mul_rst_d   = 1'b0;
    // Each pulse is set on the transition so it is visible in the next state.
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          ack_d     = pick_gnt;
          g_d       = pick_idx;
          mul_a_d   = a_sel;
          mul_b_d   = b_sel;
          mul_rst_d = 1'b1;
          state_d   = ST_CLR;
        end
      end
      ST_CLR: begin
        mul_start_d = 1'b1;
        state_d     = ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!mul_busy) begin
          result_d    = mul_result;
          done_d[g_q] = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_MAX) begin
          result_d    = '0;
          err_d       = 1'b1;
          done_d[g_q] = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = (g_q == LAST_IDX) ? '0 : g_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      result_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
      mul_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_start_q <= mul_start_d;
      mul_rst_q   <= mul_rst_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result_o  = result_q;
  assign busy      = (state_q != ST_IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = mul_start_q;
  // The shared multiplier is held in clear whenever the controller is in reset.
  assign mul_rst   = mul_rst_q | ~rst_n;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: transaction-level reference model checked every
// cycle, an iterative multiplier model, and directed scenarios.
module tb_mul_share_ctrl;

  localparam int N_REQ   = 2;
  localparam int OP_W    = 8;
  localparam int RES_W   = 16;
  localparam int TMO_CYC = 64;
  localparam int MUL_LAT = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_REQ-1:0]      req = '0;
  logic [N_REQ*OP_W-1:0] a_flat = '0;
  logic [N_REQ*OP_W-1:0] b_flat = '0;
  logic [N_REQ-1:0]      ack, done;
  logic                  err, busy;
  logic [RES_W-1:0]      result_o;
  logic [OP_W-1:0]       mul_a, mul_b;
  logic                  mul_start, mul_rst;
  logic                  mul_busy = 1'b0;
  logic [RES_W-1:0]      mul_result = '0;

  always #5 clk = ~clk;

  mul_share_ctrl #(
    .N_REQ(N_REQ), .OP_W(OP_W), .RES_W(RES_W), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .ack(ack), .done(done), .err(err), .result_o(result_o), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_rst(mul_rst),
    .mul_busy(mul_busy), .mul_result(mul_result)
  );

  // Iterative multiplier: busy rises on the edge sampling start, stays high
  // MUL_LAT cycles; with hang set it never finishes.
  logic           hang = 1'b0;
  int             mcnt = 0;
  logic [OP_W-1:0] ma = '0, mb = '0;
  always @(posedge clk) begin
    if (mul_rst) begin
      mul_busy   <= 1'b0;
      mcnt       <= 0;
      mul_result <= '0;
    end else if (mul_start) begin
      mul_busy <= 1'b1;
      mcnt     <= MUL_LAT;
      ma       <= mul_a;
      mb       <= mul_b;
    end else if (mul_busy && !hang) begin
      if (mcnt == 1) begin
        mul_busy   <= 1'b0;
        mul_result <= RES_W'(ma) * RES_W'(mb);
      end
      mcnt <= mcnt - 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int g);
    logic [N_REQ-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int rr_ref(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return 0;
  endfunction

  // Transaction logs consumed by the directed checks.
  int              ack_log[$], ack_cyc[$], done_log[$], done_cyc[$];
  logic [RES_W-1:0] res_log[$];
  logic            err_log[$];

  task automatic clr_logs();
    ack_log.delete(); ack_cyc.delete(); done_log.delete();
    done_cyc.delete(); res_log.delete(); err_log.delete();
  endtask

  // Reference model: phase 0 idle, 1 granted, 2 start, 3 waiting, 4 respond.
  initial begin
    int ph, mg, mptr, wcnt, cyc;
    logic [RES_W-1:0] mres, mexp;
    logic merr;
    logic [OP_W-1:0] ea, eb;
    ph = 0; mg = 0; mptr = 0; wcnt = 0; cyc = 0;
    mres = '0; mexp = '0; merr = 1'b0; ea = '0; eb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        check("rst_mul_rst", mul_rst, 1);
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result_o, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_mul_ab", {mul_a, mul_b}, 0);
        ph = 0; mptr = 0; mres = '0;
      end else begin
        case (ph)
          0: begin
            check("idle_ack", ack, 0);
            check("idle_done", done, 0);
            check("idle_err", err, 0);
            check("idle_busy", busy, 0);
            check("idle_mul_ctl", {mul_start, mul_rst}, 0);
            check("idle_result", result_o, mres);
            if (req != '0) begin
              mg = rr_ref(req, mptr);
              ea = a_flat[mg*OP_W +: OP_W];
              eb = b_flat[mg*OP_W +: OP_W];
              ph = 1;
            end
          end
          1: begin
            check("clr_ack", ack, onehot(mg));
            check("clr_done", done, 0);
            check("clr_busy", busy, 1);
            check("clr_mul_rst", mul_rst, 1);
            check("clr_mul_start", mul_start, 0);
            check("clr_mul_ab", {mul_a, mul_b}, {ea, eb});
            check("clr_result", result_o, mres);
            ack_log.push_back(mg);
            ack_cyc.push_back(cyc);
            ph = 2;
          end
          2: begin
            check("start_ack", ack, 0);
            check("start_done", done, 0);
            check("start_mul_ctl", {mul_start, mul_rst}, 2'b10);
            check("start_busy", busy, 1);
            check("start_mul_ab", {mul_a, mul_b}, {ea, eb});
            wcnt = 0;
            ph = 3;
          end
          3: begin
            check("wait_ack_done_err", {ack, done, err}, 0);
            check("wait_mul_ctl", {mul_start, mul_rst}, 0);
            check("wait_busy", busy, 1);
            check("wait_mul_ab", {mul_a, mul_b}, {ea, eb});
            check("wait_result", result_o, mres);
            wcnt++;
            if (!mul_busy) begin
              mexp = RES_W'(ea) * RES_W'(eb);
              merr = 1'b0;
              ph = 4;
            end else if (wcnt == TMO_CYC) begin
              mexp = '0;
              merr = 1'b1;
              ph = 4;
            end
          end
          default: begin
            check("resp_done", done, onehot(mg));
            check("resp_err", err, merr);
            check("resp_result", result_o, mexp);
            check("resp_ack", ack, 0);
            check("resp_busy", busy, 1);
            check("resp_mul_ab", {mul_a, mul_b}, {ea, eb});
            done_log.push_back(mg);
            done_cyc.push_back(cyc);
            res_log.push_back(result_o);
            err_log.push_back(err);
            mres = mexp;
            mptr = (mg + 1) % N_REQ;
            ph = 0;
          end
        endcase
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
    a_flat[i*OP_W +: OP_W] = a;
    b_flat[i*OP_W +: OP_W] = b;
  endtask

  task automatic wait_acks(input string name, input int target, input int budget);
    int c = 0;
    while (ack_log.size() < target && c < budget) begin
      tick(1);
      c++;
    end
    check(name, ack_log.size(), target);
  endtask

  task automatic wait_dones(input string name, input int target, input int budget);
    int c = 0;
    while (done_log.size() < target && c < budget) begin
      tick(1);
      c++;
    end
    check(name, done_log.size(), target);
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single request from requester 0: 7*5.
    clr_logs();
    set_op(0, 8'd7, 8'd5);
    req = 2'b01;
    wait_acks("t1_ack_cnt", 1, 10);
    req = 2'b00;
    wait_dones("t1_done_cnt", 1, 100);
    check("t1_done_idx", done_log[0], 0);
    check("t1_result", res_log[0], 35);
    check("t1_err", err_log[0], 0);
    check("t1_latency", done_cyc[0] - ack_cyc[0], 11);
    tick(1);
    check("t1_busy_low", busy, 0);
    check("t1_result_hold", result_o, 35);

    // Simultaneous requests straight after reset.
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clr_logs();
    set_op(0, 8'd3, 8'd4);
    set_op(1, 8'd255, 8'd255);
    req = 2'b11;
    wait_acks("t2_ack_cnt1", 1, 10);
    req[0] = 1'b0;
    wait_acks("t2_ack_cnt2", 2, 100);
    req[1] = 1'b0;
    wait_dones("t2_done_cnt", 2, 200);
    check("t2_ack0", ack_log[0], 0);
    check("t2_ack1", ack_log[1], 1);
    check("t2_res0", res_log[0], 12);
    check("t2_res1", res_log[1], 65025);

    // Continuous requests alternate strictly.
    clr_logs();
    set_op(0, 8'd10, 8'd20);
    set_op(1, 8'd17, 8'd3);
    req = 2'b11;
    wait_acks("t3_ack_cnt", 6, 200);
    req = 2'b00;
    wait_dones("t3_done_cnt", 6, 200);
    for (int i = 0; i < 6; i++) begin
      check("t3_grant_order", ack_log[i], i % 2);
      check("t3_result", res_log[i], (i % 2) ? 51 : 200);
    end

    // Reset while waiting on the multiplier.
    clr_logs();
    set_op(0, 8'd12, 8'd12);
    req = 2'b01;
    wait_acks("t4_ack_cnt", 1, 10);
    req = 2'b00;
    tick(3);
    check("t4_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    tick(1);
    check("t4_mul_rst_in_rst", mul_rst, 1);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("t4_no_done", done_log.size(), 0);
    check("t4_result_cleared", result_o, 0);
    check("t4_idle", busy, 0);
    set_op(1, 8'd6, 8'd7);
    req = 2'b10;
    wait_acks("t4_ack_cnt2", 2, 10);
    req = 2'b00;
    wait_dones("t4_done_cnt", 1, 100);
    check("t4_done_idx", done_log[0], 1);
    check("t4_result", res_log[0], 42);

    // Multiplier never finishes: timeout path.
    clr_logs();
    hang = 1'b1;
    set_op(1, 8'd9, 8'd9);
    req = 2'b10;
    wait_acks("t5_ack_cnt", 1, 10);
    req = 2'b00;
    wait_dones("t5_done_cnt", 1, 200);
    check("t5_done_idx", done_log[0], 1);
    check("t5_err", err_log[0], 1);
    check("t5_result", res_log[0], 0);
    check("t5_latency", done_cyc[0] - ack_cyc[0], 66);
    hang = 1'b0;
    tick(2);
    clr_logs();
    set_op(0, 8'd2, 8'd3);
    req = 2'b01;
    wait_acks("t5_ack_cnt2", 1, 10);
    req = 2'b00;
    wait_dones("t5_done_cnt2", 1, 100);
    check("t5_after_result", res_log[0], 6);
    check("t5_after_err", err_log[0], 0);

    // One-cycle request from requester 1 while requester 0 is served.
    clr_logs();
    set_op(0, 8'd4, 8'd5);
    req = 2'b01;
    wait_acks("t6_ack_cnt", 1, 10);
    req = 2'b00;
    tick(2);
    set_op(1, 8'd1, 8'd1);
    req = 2'b10;
    tick(1);
    req = 2'b00;
    wait_dones("t6_done_cnt", 1, 100);
    tick(5);
    check("t6_total_acks", ack_log.size(), 1);
    check("t6_total_dones", done_log.size(), 1);
    check("t6_done_idx", done_log[0], 0);
    check("t6_result", res_log[0], 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
